// File: rtl/tbufcam_ctl.sv
// tbufcam_ctl: records one outstanding CAM miss per thread, arbitrates both threads
//   round-robin onto one page-walk channel and installs the returned tag via the CAM
//   allocate port. Exceptions cancel the flushed thread's pending miss and any walk
//   in flight for it.
// Latency: miss in N -> stall in N+1 -> walk_req in N+2; cam_new_en in the first
//   ALLOC cycle with cam_free high. There is one IDLE cycle between services.
// Backpressure: walk_req is held until walk_ack. ALLOC holds while cam_free is low.
//   A second miss from a thread that already has a pending miss is dropped, and
//   fetch retries it while stall is high.
// Ports: clk/rst (synchronous, active-high); except/except_thread flush;
//   lk_* / cam_match* lookup ports 0/1; cam_free / cam_new_* CAM allocate port;
//   walk_* page-walk channel; stall per-thread miss pending; fault/fault_thread
//   fault pulse.
module tbufcam_ctl #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             except,
  input  logic             except_thread,
  input  logic             lk_en0,
  input  logic             lk_en1,
  input  logic [WIDTH-1:0] lk_addr0,
  input  logic [WIDTH-1:0] lk_addr1,
  input  logic             lk_thread0,
  input  logic             lk_thread1,
  input  logic             cam_match0,
  input  logic             cam_match1,
  input  logic             cam_free,
  output logic [WIDTH-1:0] cam_new_addr,
  output logic             cam_new_thread,
  output logic             cam_new_en,
  output logic             walk_req,
  output logic [WIDTH-1:0] walk_addr,
  output logic             walk_thread,
  input  logic             walk_ack,
  input  logic             walk_done,
  input  logic             walk_fault,
  output logic [1:0]       stall,
  output logic             fault,
  output logic             fault_thread
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ALLOC} state_t;

  state_t           state;
  logic [1:0]       pv;
  logic [WIDTH-1:0] pa [2];
  logic             rr;
  logic             sel;       // thread being serviced
  logic             killed;    // walk for sel was flushed; discard its result
  logic [WIDTH-1:0] cur_addr;  // tag latched at service start, stable through the handshake

  logic             miss0, miss1;
  logic [1:0]       hit;
  logic             hit_s, kill_now;
  logic             resolve, fault_fire, alloc_fire;
  logic [1:0]       elig;
  logic             pick;
  logic [1:0]       want, clr, cap;
  logic [WIDTH-1:0] cap_addr [2];

  assign miss0 = lk_en0 & ~cam_match0;
  assign miss1 = lk_en1 & ~cam_match1;
  assign hit   = {except & except_thread, except & ~except_thread};
  assign hit_s = except & (except_thread == sel);
  // A flush arriving in the same cycle as walk_done still cancels the walk.
  assign kill_now   = killed | hit_s;
  // walk_done counts in REQ only together with walk_ack.
  assign resolve    = ((state == REQ) & walk_ack | (state == WAIT)) & walk_done;
  assign fault_fire = resolve & ~kill_now & walk_fault;
  assign alloc_fire = (state == ALLOC) & cam_free & ~kill_now;

  // A thread being flushed this cycle is not started.
  assign elig = pv & ~hit;
  assign pick = (&elig) ? rr : elig[1];

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      want[t]     = 1'b0;
      cap_addr[t] = lk_addr0;
      // Port 0 wins when both ports miss for the same thread.
      if (miss0 && lk_thread0 == 1'(t)) begin
        want[t]     = 1'b1;
        cap_addr[t] = lk_addr0;
      end else if (miss1 && lk_thread1 == 1'(t)) begin
        want[t]     = 1'b1;
        cap_addr[t] = lk_addr1;
      end
      clr[t] = (alloc_fire | fault_fire) & (sel == 1'(t));
      // A slot being retired this cycle can accept a new miss immediately.
      cap[t] = want[t] & (~pv[t] | clr[t]) & ~hit[t];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pv           <= 2'b00;
      pa[0]        <= '0;
      pa[1]        <= '0;
      rr           <= 1'b0;
      sel          <= 1'b0;
      killed       <= 1'b0;
      cur_addr     <= '0;
      fault        <= 1'b0;
      fault_thread <= 1'b0;
    end else begin
      for (int t = 0; t < 2; t++) begin
        if (hit[t]) begin
          pv[t] <= 1'b0;
        end else if (cap[t]) begin
          pv[t] <= 1'b1;
          pa[t] <= cap_addr[t];
        end else if (clr[t]) begin
          pv[t] <= 1'b0;
        end
      end

      fault <= fault_fire;
      if (fault_fire) fault_thread <= sel;

      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (|elig) begin
            sel      <= pick;
            cur_addr <= pa[pick];
            if (&elig) rr <= ~pick;  // rotate only when both threads contend
            state    <= REQ;
          end
        end
        REQ, WAIT: begin
          if (resolve) begin
            state  <= (kill_now | walk_fault) ? IDLE : ALLOC;
            killed <= 1'b0;
          end else begin
            if (state == REQ && walk_ack) state <= WAIT;
            if (hit_s) killed <= 1'b1;
          end
        end
        ALLOC: begin
          if (hit_s | cam_free) begin
            state  <= IDLE;
            killed <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign walk_req       = (state == REQ);
  assign walk_addr      = cur_addr;
  assign walk_thread    = sel;
  assign cam_new_addr   = cur_addr;
  assign cam_new_thread = sel;
  assign cam_new_en     = alloc_fire;
  assign stall          = pv;

endmodule

// File: tb/tb_tbufcam_ctl.sv
module tb_tbufcam_ctl;
  localparam int W = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, except = 1'b0, except_thread = 1'b0;
  logic         lk_en0 = 1'b0, lk_en1 = 1'b0;
  logic [W-1:0] lk_addr0 = '0, lk_addr1 = '0;
  logic         lk_thread0 = 1'b0, lk_thread1 = 1'b0, cam_match0 = 1'b0, cam_match1 = 1'b0;
  logic         cam_free = 1'b0, walk_ack = 1'b0, walk_done = 1'b0, walk_fault = 1'b0;
  logic [W-1:0] cam_new_addr, walk_addr;
  logic         cam_new_thread, cam_new_en, walk_req, walk_thread, fault, fault_thread;
  logic [1:0]   stall;

  tbufcam_ctl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
    .lk_en0(lk_en0), .lk_en1(lk_en1), .lk_addr0(lk_addr0), .lk_addr1(lk_addr1),
    .lk_thread0(lk_thread0), .lk_thread1(lk_thread1),
    .cam_match0(cam_match0), .cam_match1(cam_match1), .cam_free(cam_free),
    .cam_new_addr(cam_new_addr), .cam_new_thread(cam_new_thread), .cam_new_en(cam_new_en),
    .walk_req(walk_req), .walk_addr(walk_addr), .walk_thread(walk_thread),
    .walk_ack(walk_ack), .walk_done(walk_done), .walk_fault(walk_fault),
    .stall(stall), .fault(fault), .fault_thread(fault_thread)
  );

  typedef struct packed {
    logic rs, ex, ext, en0; logic [W-1:0] a0; logic t0, m0, en1; logic [W-1:0] a1;
    logic t1, m1, free, ack, done, flt;
  } in_t;

  typedef struct {
    in_t i; logic [1:0] st; logic rq, ne, fl; logic [W-1:0] na;
  } row_t;

  in_t  iv;
  row_t rows[$];
  int   nchk = 0, nerr = 0;

  // Reference model: pending slots plus one in-service transaction described
  // by what has happened to it so far (requested, acknowledged, walked, doomed).
  bit           mpv[2];
  logic [W-1:0] mpa[2];
  bit           mrr, mbusy, macked, mwalked, mdoomed, msel, mflt, mflt_t;
  logic [W-1:0] mtag;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpv[0] = 0; mpv[1] = 0; mpa[0] = '0; mpa[1] = '0;
    mrr = 0; mbusy = 0; macked = 0; mwalked = 0; mdoomed = 0; msel = 0;
    mflt = 0; mflt_t = 0; mtag = '0;
  endtask

  task automatic model_check();
    bit e_req, e_nen;
    e_req = mbusy & ~macked;
    e_nen = mbusy & mwalked & iv.free & ~(iv.ex & (iv.ext == msel));
    chk("m_stall", 32'(stall), 32'({mpv[1], mpv[0]}));
    chk("m_walk_req", 32'(walk_req), 32'(e_req));
    if (e_req) begin
      chk("m_walk_addr", 32'(walk_addr), 32'(mtag));
      chk("m_walk_thread", 32'(walk_thread), 32'(msel));
    end
    chk("m_cam_new_en", 32'(cam_new_en), 32'(e_nen));
    if (e_nen) begin
      chk("m_cam_new_addr", 32'(cam_new_addr), 32'(mtag));
      chk("m_cam_new_thread", 32'(cam_new_thread), 32'(msel));
    end
    chk("m_fault", 32'(fault), 32'(mflt));
    if (mflt) chk("m_fault_thread", 32'(fault_thread), 32'(mflt_t));
  endtask

  task automatic model_step();
    bit hit[2];
    bit hs, nflt, doom, got, el0, el1, pk, want;
    int clr;
    logic [W-1:0] wa;
    hit[0] = iv.ex & ~iv.ext;
    hit[1] = iv.ex & iv.ext;
    hs = hit[msel]; clr = -1; nflt = 0;
    if (mbusy) begin
      if (mwalked) begin
        if (hs) mbusy = 0;
        else if (iv.free) begin clr = int'(msel); mbusy = 0; end
      end else begin
        doom = mdoomed | hs;
        got  = macked ? iv.done : (iv.ack & iv.done);
        if (iv.ack) macked = 1;
        if (got) begin
          if (doom) mbusy = 0;
          else if (iv.flt) begin nflt = 1; clr = int'(msel); mbusy = 0; end
          else mwalked = 1;
        end else mdoomed = doom;
      end
    end else begin
      el0 = mpv[0] & ~hit[0];
      el1 = mpv[1] & ~hit[1];
      if (el0 | el1) begin
        pk = (el0 & el1) ? mrr : el1;
        if (el0 & el1) mrr = ~pk;
        mbusy = 1; macked = 0; mwalked = 0; mdoomed = 0; msel = pk; mtag = mpa[pk];
      end
    end
    if (nflt) mflt_t = msel;
    mflt = nflt;
    for (int t = 0; t < 2; t++) begin
      want = 0; wa = '0;
      if (iv.en0 & ~iv.m0 & (iv.t0 == 1'(t))) begin want = 1; wa = iv.a0; end
      else if (iv.en1 & ~iv.m1 & (iv.t1 == 1'(t))) begin want = 1; wa = iv.a1; end
      if (hit[t]) mpv[t] = 0;
      else if (want & (!mpv[t] | clr == t)) begin mpv[t] = 1; mpa[t] = wa; end
      else if (clr == t) mpv[t] = 0;
    end
  endtask

  // One clock cycle: drive iv after the falling edge, check, advance the model.
  task automatic cyc();
    @(negedge clk);
    rst = iv.rs; except = iv.ex; except_thread = iv.ext;
    lk_en0 = iv.en0; lk_addr0 = iv.a0; lk_thread0 = iv.t0; cam_match0 = iv.m0;
    lk_en1 = iv.en1; lk_addr1 = iv.a1; lk_thread1 = iv.t1; cam_match1 = iv.m1;
    cam_free = iv.free; walk_ack = iv.ack; walk_done = iv.done; walk_fault = iv.flt;
    #1;
    if (iv.rs) model_reset();
    else begin model_check(); model_step(); end
  endtask

  function automatic in_t mk_nop(logic free);
    in_t v; v = '0; v.free = free; return v;
  endfunction

  function automatic in_t mk_walk(logic ack, logic done, logic flt, logic free);
    in_t v; v = mk_nop(free); v.ack = ack; v.done = done; v.flt = flt; return v;
  endfunction

  function automatic in_t mk_miss(logic port, logic thr, logic [W-1:0] a, logic free);
    in_t v; v = mk_nop(free);
    if (!port) begin v.en0 = 1; v.t0 = thr; v.a0 = a; end
    else begin v.en1 = 1; v.t1 = thr; v.a1 = a; end
    return v;
  endfunction

  function automatic in_t mk_flush(logic thr, logic free);
    in_t v; v = mk_nop(free); v.ex = 1; v.ext = thr; return v;
  endfunction

  task automatic add(in_t i, logic [1:0] st, logic rq, logic ne, logic fl, logic [W-1:0] na);
    row_t r; r.i = i; r.st = st; r.rq = rq; r.ne = ne; r.fl = fl; r.na = na;
    rows.push_back(r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    iv = mk_nop(0); iv.rs = 1;
    repeat (3) cyc();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_walk_req", 32'(walk_req), 0);
    chk("rst_cam_new_en", 32'(cam_new_en), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_fault_thread", 32'(fault_thread), 0);
    chk("rst_walk_addr", 32'(walk_addr), 0);
    chk("rst_walk_thread", 32'(walk_thread), 0);
    chk("rst_cam_new_addr", 32'(cam_new_addr), 0);
    chk("rst_cam_new_thread", 32'(cam_new_thread), 0);

    // Single miss, faulted walk, allocation delayed by a full CAM.
    add(mk_miss(0, 0, 11'h123, 1), 2'b00, 0, 0, 0, '0);
    add(mk_nop(1),                 2'b01, 0, 0, 0, '0);
    add(mk_nop(1),                 2'b01, 1, 0, 0, '0);
    add(mk_walk(1, 0, 0, 1),       2'b01, 1, 0, 0, '0);
    add(mk_nop(1),                 2'b01, 0, 0, 0, '0);
    add(mk_walk(0, 1, 0, 1),       2'b01, 0, 0, 0, '0);
    add(mk_nop(1),                 2'b01, 0, 1, 0, 11'h123);
    add(mk_nop(1),                 2'b00, 0, 0, 0, '0);
    add(mk_miss(1, 1, 11'h0AB, 1), 2'b00, 0, 0, 0, '0);
    add(mk_nop(1),                 2'b10, 0, 0, 0, '0);
    add(mk_walk(1, 0, 0, 1),       2'b10, 1, 0, 0, '0);
    add(mk_walk(0, 1, 1, 1),       2'b10, 0, 0, 0, '0);
    add(mk_nop(1),                 2'b00, 0, 0, 1, '0);
    add(mk_nop(1),                 2'b00, 0, 0, 0, '0);
    add(mk_miss(1, 0, 11'h3C5, 1), 2'b00, 0, 0, 0, '0);
    add(mk_nop(1),                 2'b01, 0, 0, 0, '0);
    add(mk_walk(1, 0, 0, 1),       2'b01, 1, 0, 0, '0);
    add(mk_walk(0, 1, 0, 0),       2'b01, 0, 0, 0, '0);
    add(mk_nop(0),                 2'b01, 0, 0, 0, '0);
    add(mk_nop(0),                 2'b01, 0, 0, 0, '0);
    add(mk_nop(0),                 2'b01, 0, 0, 0, '0);
    add(mk_nop(1),                 2'b01, 0, 1, 0, 11'h3C5);
    add(mk_nop(1),                 2'b00, 0, 0, 0, '0);
    foreach (rows[k]) begin
      iv = rows[k].i;
      cyc();
      chk($sformatf("row%0d_stall", k), 32'(stall), 32'(rows[k].st));
      chk($sformatf("row%0d_walk_req", k), 32'(walk_req), 32'(rows[k].rq));
      chk($sformatf("row%0d_cam_new_en", k), 32'(cam_new_en), 32'(rows[k].ne));
      chk($sformatf("row%0d_fault", k), 32'(fault), 32'(rows[k].fl));
      if (rows[k].ne) chk($sformatf("row%0d_cam_new_addr", k), 32'(cam_new_addr), 32'(rows[k].na));
      if (rows[k].fl) chk($sformatf("row%0d_fault_thread", k), 32'(fault_thread), 1);
    end

    // Dual-thread arbitration, then a second pair after rr has rotated.
    iv = mk_miss(0, 0, 11'h010, 1); iv.en1 = 1; iv.t1 = 1; iv.a1 = 11'h020; cyc();
    iv = mk_nop(1); cyc(); chk("arb_stall_both", 32'(stall), 3);
    iv = mk_walk(1, 1, 0, 1); cyc();
    chk("arb1_thread", 32'(walk_thread), 0); chk("arb1_addr", 32'(walk_addr), 'h010);
    iv = mk_nop(1); cyc(); chk("arb1_alloc", 32'(cam_new_en), 1); chk("arb1_nthr", 32'(cam_new_thread), 0);
    iv = mk_nop(1); cyc();
    iv = mk_walk(1, 1, 0, 1); cyc();
    chk("arb2_thread", 32'(walk_thread), 1); chk("arb2_addr", 32'(walk_addr), 'h020);
    iv = mk_nop(1); cyc(); chk("arb2_alloc_addr", 32'(cam_new_addr), 'h020);
    iv = mk_miss(0, 0, 11'h011, 1); iv.en1 = 1; iv.t1 = 1; iv.a1 = 11'h021; cyc();
    iv = mk_nop(1); cyc();
    iv = mk_walk(1, 1, 0, 1); cyc();
    chk("arb3_thread", 32'(walk_thread), 1); chk("arb3_addr", 32'(walk_addr), 'h021);
    iv = mk_nop(1); cyc();
    iv = mk_nop(1); cyc();
    iv = mk_walk(1, 1, 0, 1); cyc();
    chk("arb4_thread", 32'(walk_thread), 0); chk("arb4_addr", 32'(walk_addr), 'h011);
    iv = mk_nop(1); cyc();
    iv = mk_nop(1); cyc(); chk("arb_stall_clear", 32'(stall), 0);

    // Same-thread double miss: only port 0 captured.
    iv = mk_miss(0, 1, 11'h055, 1); iv.en1 = 1; iv.t1 = 1; iv.a1 = 11'h066; cyc();
    iv = mk_nop(1); cyc();
    iv = mk_walk(1, 1, 0, 1); cyc(); chk("dbl_addr", 32'(walk_addr), 'h055);
    iv = mk_nop(1); cyc(); chk("dbl_alloc_addr", 32'(cam_new_addr), 'h055);
    iv = mk_nop(1); cyc(); chk("dbl_stall", 32'(stall), 0); chk("dbl_no_req", 32'(walk_req), 0);

    // Flush during WAIT.
    iv = mk_miss(0, 0, 11'h200, 1); cyc();
    iv = mk_nop(1); cyc();
    iv = mk_walk(1, 0, 0, 1); cyc();
    iv = mk_flush(0, 1); cyc(); chk("exw_stall_hold", 32'(stall), 1);
    iv = mk_walk(0, 1, 0, 1); cyc(); chk("exw_stall_drop", 32'(stall), 0);
    iv = mk_nop(1); cyc(); chk("exw_no_alloc", 32'(cam_new_en), 0); chk("exw_no_fault", 32'(fault), 0);
    iv = mk_nop(1); cyc(); chk("exw_idle", 32'(walk_req), 0);

    // Flush during REQ with ack withheld for 5 cycles.
    iv = mk_miss(1, 1, 11'h1F0, 1); cyc();
    iv = mk_nop(1); cyc();
    iv = mk_flush(1, 1); cyc(); chk("exr_req0", 32'(walk_req), 1);
    for (int k = 1; k < 5; k++) begin
      iv = mk_nop(1); cyc(); chk($sformatf("exr_req%0d", k), 32'(walk_req), 1);
    end
    chk("exr_stall", 32'(stall), 0);
    iv = mk_walk(1, 1, 0, 1); cyc(); chk("exr_addr", 32'(walk_addr), 'h1F0);
    iv = mk_nop(1); cyc(); chk("exr_no_alloc", 32'(cam_new_en), 0); chk("exr_req_off", 32'(walk_req), 0);

    // Reset mid-walk; late ack/done ignored.
    iv = mk_miss(0, 0, 11'h0F0, 1); cyc();
    iv = mk_nop(1); cyc();
    iv = mk_nop(1); cyc(); chk("rmw_req", 32'(walk_req), 1);
    iv = mk_nop(1); iv.rs = 1; cyc();
    iv = mk_walk(1, 1, 0, 1); cyc(); chk("rmw_req_off", 32'(walk_req), 0); chk("rmw_stall", 32'(stall), 0);
    iv = mk_nop(1); cyc(); chk("rmw_no_alloc", 32'(cam_new_en), 0); chk("rmw_idle", 32'(walk_req), 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      in_t v;
      v = '0;
      v.rs   = ($urandom_range(0, 499) == 0);
      v.ex   = ($urandom_range(0, 9) == 0);
      v.ext  = 1'($urandom);
      v.en0  = 1'($urandom); v.a0 = W'($urandom); v.t0 = 1'($urandom); v.m0 = 1'($urandom);
      v.en1  = 1'($urandom); v.a1 = W'($urandom); v.t1 = 1'($urandom); v.m1 = 1'($urandom);
      v.free = ($urandom_range(0, 2) != 0);
      v.ack  = mbusy & ~macked & ($urandom_range(0, 2) == 0);
      v.done = mbusy & ~mwalked & (macked | v.ack) & ($urandom_range(0, 2) == 0);
      v.flt  = 1'($urandom);
      iv = v;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
